// File: rtl/e_mdu_pkg.sv
// ============================================================================
// Module   : e_mdu_pkg
// Brief    : MDU opcode encodings, FSM states and completion-action codes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package e_mdu_pkg;

   localparam logic [3:0] MDU_NONE  = 4'd0;
   localparam logic [3:0] MDU_MULT  = 4'd1;
   localparam logic [3:0] MDU_MULTU = 4'd2;
   localparam logic [3:0] MDU_DIV   = 4'd3;
   localparam logic [3:0] MDU_DIVU  = 4'd4;
   localparam logic [3:0] MDU_MFHI  = 4'd5;
   localparam logic [3:0] MDU_MFLO  = 4'd6;
   localparam logic [3:0] MDU_MTHI  = 4'd7;
   localparam logic [3:0] MDU_MTLO  = 4'd8;
   localparam logic [3:0] MDU_MADD  = 4'd9;
   localparam logic [3:0] MDU_MADDU = 4'd10;
   localparam logic [3:0] MDU_MSUB  = 4'd11;
   localparam logic [3:0] MDU_MSUBU = 4'd12;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } mdu_state_e;

   // What to do with {HI,LO} when the pending operation completes.
   typedef enum logic [1:0] {
      ACC_SET  = 2'd0,
      ACC_ADD  = 2'd1,
      ACC_SUB  = 2'd2,
      ACC_NONE = 2'd3
   } mdu_acc_e;

endpackage

`default_nettype wire

// File: rtl/e_mdu.sv
// ============================================================================
// Module   : e_mdu
// Brief    : E-stage multi-cycle multiply/divide unit owning HI/LO.
//            Optional macro MDU_MADD_EN enables madd/maddu/msub/msubu.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module e_mdu
   import e_mdu_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  MDUOp,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] MDUOut
);

   localparam int c_max_cyc = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int c_cw      = (c_max_cyc > 1) ? $clog2(c_max_cyc) : 1;
   localparam logic [c_cw-1:0] c_mult_m1 = c_cw'(MULT_CYCLES - 1);
   localparam logic [c_cw-1:0] c_div_m1  = c_cw'(DIV_CYCLES - 1);

   mdu_state_e      r_state, w_state_nxt;
   logic [c_cw-1:0] r_cnt, w_cnt_nxt, w_len_m1;
   logic [63:0]     r_pend, w_res;
   mdu_acc_e        r_acc, w_acc;
   logic [31:0]     r_hi, r_lo;
   logic            w_go, w_load, w_done;

   logic [63:0] w_prod_s, w_prod_u;
   logic [31:0] w_dvs_u, w_qu, w_ru;
   logic [31:0] w_a_mag, w_b_mag, w_qm, w_rm, w_qs, w_rs;

   assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
   assign w_prod_u = {32'd0, A} * {32'd0, B};

   // Divisor forced to 1 on zero only to keep the datapath defined; the
   // result is never written back in that case.
   assign w_dvs_u = (B == 32'd0) ? 32'd1 : B;
   assign w_qu    = A / w_dvs_u;
   assign w_ru    = A % w_dvs_u;

   // Signed divide via magnitudes avoids the INT_MIN / -1 overflow trap.
   assign w_a_mag = A[31] ? (~A + 32'd1) : A;
   assign w_b_mag = B[31] ? (~B + 32'd1) : w_dvs_u;
   assign w_qm    = w_a_mag / w_b_mag;
   assign w_rm    = w_a_mag % w_b_mag;
   assign w_qs    = (A[31] ^ B[31]) ? (~w_qm + 32'd1) : w_qm;
   assign w_rs    = A[31] ? (~w_rm + 32'd1) : w_rm;

   always_comb begin
      w_go     = 1'b0;
      w_res    = w_prod_u;
      w_acc    = ACC_SET;
      w_len_m1 = c_mult_m1;
      case (MDUOp)
         MDU_MULT:  begin w_go = 1'b1; w_res = w_prod_s; end
         MDU_MULTU: begin w_go = 1'b1; end
         MDU_DIV: begin
            w_go     = 1'b1;
            w_res    = {w_rs, w_qs};
            w_len_m1 = c_div_m1;
            if (B == 32'd0) w_acc = ACC_NONE;
         end
         MDU_DIVU: begin
            w_go     = 1'b1;
            w_res    = {w_ru, w_qu};
            w_len_m1 = c_div_m1;
            if (B == 32'd0) w_acc = ACC_NONE;
         end
`ifdef MDU_MADD_EN
         MDU_MADD:  begin w_go = 1'b1; w_res = w_prod_s; w_acc = ACC_ADD; end
         MDU_MADDU: begin w_go = 1'b1; w_acc = ACC_ADD; end
         MDU_MSUB:  begin w_go = 1'b1; w_res = w_prod_s; w_acc = ACC_SUB; end
         MDU_MSUBU: begin w_go = 1'b1; w_acc = ACC_SUB; end
`endif
         default: ;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_load      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            if (start && w_go) begin
               w_state_nxt = RUN;
               w_cnt_nxt   = w_len_m1;
               w_load      = 1'b1;
            end
         end
         RUN: begin
            if (r_cnt == '0) begin
               w_state_nxt = IDLE;
               w_done      = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - c_cw'(1);
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pend <= 64'd0;
         r_acc  <= ACC_SET;
         r_hi   <= 32'd0;
         r_lo   <= 32'd0;
      end else begin
         if (w_load) begin
            r_pend <= w_res;
            r_acc  <= w_acc;
         end
         if (w_done) begin
            case (r_acc)
               ACC_SET: {r_hi, r_lo} <= r_pend;
               ACC_ADD: {r_hi, r_lo} <= {r_hi, r_lo} + r_pend;
               ACC_SUB: {r_hi, r_lo} <= {r_hi, r_lo} - r_pend;
               default: ;
            endcase
         end else if (r_state == IDLE) begin
            if (MDUOp == MDU_MTHI) r_hi <= A;
            if (MDUOp == MDU_MTLO) r_lo <= A;
         end
      end
   end

   assign busy = (r_state == RUN);

   always_comb begin
      MDUOut = 32'd0;
      if (MDUOp == MDU_MFHI) MDUOut = r_hi;
      else if (MDUOp == MDU_MFLO) MDUOut = r_lo;
   end

endmodule

`default_nettype wire
